cp0_exc_ctrl: RTL
=================

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h0000_0020, exception/interrupt handler entry PC.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 inst_valid_i  in  1  MEM-stage instruction valid; interrupts are taken only on a valid instruction.
REQ-005 exc_req_i  in  1  synchronous exception request from MEM stage.
REQ-006 exc_code_i  in  5  ExcCode of the requested exception.
REQ-007 exc_pc_i  in  32  PC of the MEM-stage instruction.
REQ-008 in_delay_slot_i  in  1  MEM-stage instruction is in a branch delay slot.
REQ-009 eret_i  in  1  MEM-stage ERET.
REQ-010 mtc0_we_i, mtc0_waddr_i[4:0], mtc0_data_i[31:0]  in  pipeline MTC0 write request.
REQ-011 cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 Status/Cause/EPC.
REQ-012 cp0_we_o, cp0_waddr_o[4:0], cp0_data_o[31:0]  out  single CP0 write port.
REQ-013 stall_o  out  1  freeze pipeline; flush_o  out  1  kill all stages; new_pc_o  out  32  redirect target, valid with flush_o.

Function
REQ-014 States: IDLE, EXC_EPC, EXC_CAUSE, EXC_STATUS, EXC_REDIR, ERET_STATUS, ERET_REDIR; state registered, outputs decoded from state.
REQ-015 int_pend = Status[0] & ~Status[1] & |(Cause[15:8] & Status[15:8]).
REQ-016 Trigger priority in IDLE: int_pend&inst_valid_i (code 5'd0) > exc_req_i (exc_code_i) > eret_i; lower-priority triggers in the same cycle are dropped.
REQ-017 On exception/interrupt trigger in cycle T: latch pc, code, bd; state EXC_EPC at T+1, EXC_CAUSE T+2, EXC_STATUS T+3, EXC_REDIR T+4, IDLE T+5.
REQ-018 EXC_EPC: write addr 14, data = bd ? pc-4 : pc (32-bit wrap); if Status[1] (EXL) was 1 at trigger, cp0_we_o=0 in this state and EPC is not overwritten.
REQ-019 EXC_CAUSE: write addr 13, data = {bd, Cause[30:7], code, Cause[1:0]}; bd forced 0 when EXL was 1 at trigger.
REQ-020 EXC_STATUS: write addr 12, data = cp0_status_i | 32'h2.
REQ-021 EXC_REDIR: flush_o=1, new_pc_o=EXC_VECTOR, no write.
REQ-022 ERET trigger at T: ERET_STATUS at T+1 writes addr 12 with cp0_status_i & ~32'h2; ERET_REDIR at T+2 flush_o=1, new_pc_o=cp0_epc_i; IDLE at T+3.
REQ-023 stall_o = 1 in trigger cycle and every non-IDLE state; 0 in IDLE without trigger.
REQ-024 IDLE without trigger: cp0 write port passes mtc0_* through combinationally, zero latency.
REQ-025 Trigger coincident with mtc0_we_i: MTC0 dropped (its instruction is flushed); cp0_we_o=0 in trigger cycle.
REQ-026 mtc0_we_i in non-IDLE states ignored (pipeline stalled); no trigger accepted until IDLE.
REQ-027 flush_o high exactly one cycle per sequence; new_pc_o = 0 when flush_o=0.
REQ-028 Outputs with no active drive are 0 (cp0_waddr_o, cp0_data_o included).

Reset
REQ-029 rst_n=0 at a rising edge: state IDLE, latched pc/code/bd cleared, all outputs 0 from that cycle, including mid-sequence; no partial write completes after reset.

Structure
REQ-030 Shared macro header holds CP0 addresses (STATUS 12, CAUSE 13, EPC 14), ExcCode constants (Int 0, Syscall 8, RI 10, Ov 12), state encodings and EXC_VECTOR default.
REQ-031 One sub-module cp0_int_pending (combinational REQ-015); sequencer remains flat.

Verification
REQ-032 exc_req_i=1, code 8, pc 32'h100, bd 0, EXL 0 -> T+1 EPC<=0x100, T+2 Cause[6:2]=8, T+3 Status|=2, T+4 flush_o, new_pc_o=0x20.
REQ-033 Delay-slot exception pc 32'h204, bd 1 -> EPC<=0x200, Cause[31]=1.
REQ-034 Status=32'h0000_0401, Cause[10]=1, inst_valid_i=1 with simultaneous exc_req_i code 12 -> interrupt taken, Cause[6:2]=0.
REQ-035 exc_req_i with Status EXL=1 -> no EPC write at T+1, Cause BD=0, redirect at T+4.
REQ-036 eret_i, EPC 32'h300 -> T+1 Status EXL cleared, T+2 flush_o, new_pc_o=0x300; mtc0 in IDLE passes through; mtc0 with trigger dropped.
REQ-037 rst_n low during EXC_CAUSE -> next cycle IDLE, cp0_we_o=0, stall_o=0.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// cp0_exc_ctrl_pkg: CP0 register addresses, ExcCodes, sequencer states and vector default.
package cp0_exc_ctrl_pkg;
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC = 5'd14;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI = 5'd10;
  localparam logic [4:0] EXC_OV = 5'd12;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
  typedef enum logic [2:0] {
    S_IDLE, S_EXC_EPC, S_EXC_CAUSE, S_EXC_STATUS, S_EXC_REDIR, S_ERET_STATUS, S_ERET_REDIR
  } state_t;
endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// cp0_exc_ctrl_if: MEM-stage trigger inputs, CP0 register view and CP0 write/redirect outputs.
interface cp0_exc_ctrl_if;
  logic        inst_valid_i;
  logic        exc_req_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        in_delay_slot_i;
  logic        eret_i;
  logic        mtc0_we_i;
  logic [4:0]  mtc0_waddr_i;
  logic [31:0] mtc0_data_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_data_o;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  modport master (
    output inst_valid_i, exc_req_i, exc_code_i, exc_pc_i, in_delay_slot_i, eret_i,
           mtc0_we_i, mtc0_waddr_i, mtc0_data_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  cp0_we_o, cp0_waddr_o, cp0_data_o, stall_o, flush_o, new_pc_o
  );
  modport slave (
    input  inst_valid_i, exc_req_i, exc_code_i, exc_pc_i, in_delay_slot_i, eret_i,
           mtc0_we_i, mtc0_waddr_i, mtc0_data_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
    output cp0_we_o, cp0_waddr_o, cp0_data_o, stall_o, flush_o, new_pc_o
  );
endinterface

// File: rtl/cp0_exc_ctrl_int_pending.sv
// cp0_int_pending: interrupt pending when IE set, EXL clear and any unmasked IP bit.
module cp0_int_pending (
  input  logic       i_ie,
  input  logic       i_exl,
  input  logic [7:0] i_im,
  input  logic [7:0] i_ip,
  output logic       o_pend
);
  assign o_pend = i_ie & ~i_exl & |(i_ip & i_im);
endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: sequences exception/ERET CP0 writes through one write port, then redirects the PC.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input logic clk,
  input logic rst_n,
  cp0_exc_ctrl_if.slave bus
);
  state_t r_state, w_next;
  logic [31:0] r_pc;
  logic [4:0]  r_code;
  logic        r_bd, r_exl;
  logic        w_int_pend, w_idle, w_int_trig, w_exc_trig, w_eret_trig;
  logic        w_we, w_stall, w_flush;
  logic [4:0]  w_addr;
  logic [31:0] w_data, w_new_pc;
  cp0_int_pending u_int_pending (
    .i_ie   (bus.cp0_status_i[0]),
    .i_exl  (bus.cp0_status_i[1]),
    .i_im   (bus.cp0_status_i[15:8]),
    .i_ip   (bus.cp0_cause_i[15:8]),
    .o_pend (w_int_pend)
  );
  assign w_idle = r_state == S_IDLE;
  assign w_int_trig = rst_n & w_idle & w_int_pend & bus.inst_valid_i;
  assign w_exc_trig = w_int_trig | (rst_n & w_idle & bus.exc_req_i);
  assign w_eret_trig = rst_n & w_idle & ~w_exc_trig & bus.eret_i;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc <= '0;
      r_code <= '0;
      r_bd <= 1'b0;
      r_exl <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_exc_trig) begin
        r_pc <= bus.exc_pc_i;
        r_code <= w_int_trig ? EXC_INT : bus.exc_code_i;
        r_bd <= bus.in_delay_slot_i;
        r_exl <= bus.cp0_status_i[1];
      end
    end
  end
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:        w_next = w_exc_trig ? S_EXC_EPC : w_eret_trig ? S_ERET_STATUS : S_IDLE;
      S_EXC_EPC:     w_next = S_EXC_CAUSE;
      S_EXC_CAUSE:   w_next = S_EXC_STATUS;
      S_EXC_STATUS:  w_next = S_EXC_REDIR;
      S_ERET_STATUS: w_next = S_ERET_REDIR;
      default:       w_next = S_IDLE;
    endcase
  end
  // A nested exception (EXL already set) keeps the original EPC and reports BD=0.
  always_comb begin
    w_we = 1'b0;
    w_addr = '0;
    w_data = '0;
    w_flush = 1'b0;
    w_new_pc = '0;
    w_stall = ~w_idle | w_exc_trig | w_eret_trig;
    case (r_state)
      S_IDLE: if (!w_stall && bus.mtc0_we_i) begin
        w_we = 1'b1;
        w_addr = bus.mtc0_waddr_i;
        w_data = bus.mtc0_data_i;
      end
      S_EXC_EPC: if (!r_exl) begin
        w_we = 1'b1;
        w_addr = CP0_EPC;
        w_data = r_bd ? r_pc - 32'd4 : r_pc;
      end
      S_EXC_CAUSE: begin
        w_we = 1'b1;
        w_addr = CP0_CAUSE;
        w_data = {r_bd & ~r_exl, bus.cp0_cause_i[30:7], r_code, bus.cp0_cause_i[1:0]};
      end
      S_EXC_STATUS: begin
        w_we = 1'b1;
        w_addr = CP0_STATUS;
        w_data = bus.cp0_status_i | 32'h2;
      end
      S_EXC_REDIR: begin
        w_flush = 1'b1;
        w_new_pc = EXC_VECTOR;
      end
      S_ERET_STATUS: begin
        w_we = 1'b1;
        w_addr = CP0_STATUS;
        w_data = bus.cp0_status_i & ~32'h2;
      end
      S_ERET_REDIR: begin
        w_flush = 1'b1;
        w_new_pc = bus.cp0_epc_i;
      end
      default: ;
    endcase
  end
  // Reset silences every output in the same cycle, even mid-sequence.
  assign bus.cp0_we_o = rst_n & w_we;
  assign bus.cp0_waddr_o = rst_n ? w_addr : '0;
  assign bus.cp0_data_o = rst_n ? w_data : '0;
  assign bus.stall_o = rst_n & w_stall;
  assign bus.flush_o = rst_n & w_flush;
  assign bus.new_pc_o = rst_n ? w_new_pc : '0;
endmodule
